table_cfg_writer: RTL and testbench
===================================

# table_cfg_writer

Control-plane writer that drives the lookup/action control channels of the match-action stages. It accepts configuration messages on a 64-bit valid/ready stream and reassembles multi-beat CAM entries (key + mask) and action words. It then issues single-cycle write strobes to the lookup CAM or action RAM of the addressed stage (0-4). It sits between the control-packet filter and the five stage instances; it is the only source of `lookup_din*` and `action_*` writes.

## Interface
- `KEY_LEN`, 896: CAM key width. Must be a multiple of `CTRL_W`.
- `MASK_LEN`, 896: CAM mask width. Must equal `KEY_LEN`.
- `ACTION_LEN`, 25: action word width. Must be ≤ `CTRL_W`.
- `ADDR_W`, 4: CAM/action RAM address width.
- `NUM_STAGES`, 5: number of stages addressed.
- `CTRL_W`, 64: control stream data width.
- `axis_clk` in 1: single clock.
- `aresetn` in 1: asynchronous, active-low reset.
- `ctrl_data` in CTRL_W: control beat.
- `ctrl_valid` in 1: beat valid.
- `ctrl_last` in 1: final beat of message.
- `ctrl_ready` out 1: writer accepts beat.
- `lookup_din` out KEY_LEN: CAM key.
- `lookup_din_mask` out MASK_LEN: CAM mask.
- `lookup_din_addr` out ADDR_W: CAM address.
- `lookup_din_en` out NUM_STAGES: one-hot CAM write strobe per stage.
- `action_data_in` out ACTION_LEN: action word.
- `action_addr` out ADDR_W: action RAM address.
- `action_en` out NUM_STAGES: one-hot action write strobe per stage.
- `err_cnt` out 16: malformed-message count (only with `TABLE_CFG_ERR_CNT_EN`).

## Operation
- Beat transfer: a beat transfers on `ctrl_valid && ctrl_ready`.
- Header beat (first beat of every message):
  - [63:60] opcode: 1 = CAM write, 2 = action write, other = invalid.
  - [59:57] stage id.
  - [ADDR_W-1:0] address.
- Payload:
  - CAM message: KEY_LEN/CTRL_W key beats (14), then the same number of mask beats. Least-significant beat comes first.
  - Action message: one beat; `ACTION_LEN` LSBs used.
- FSM states:
  - IDLE: wait for header.
  - KEY: counter `beat_cnt` runs 0..13, shifting into the key register.
  - MASK: same, into the mask register.
  - ACT: capture action beat.
  - ISSUE: one cycle; strobe asserted.
  - DRAIN: discard beats until `ctrl_last`.
- Transitions:
  - IDLE→KEY on opcode 1; IDLE→ACT on opcode 2.
  - KEY→MASK after beat 13; MASK→ISSUE after beat 13; ACT→ISSUE.
  - ISSUE→IDLE.
- Error paths:
  - Invalid opcode, or stage id ≥ NUM_STAGES, in header: go to DRAIN, or directly to IDLE if the header carries `ctrl_last`.
  - `ctrl_last` seen before the final payload beat: abort to IDLE with no strobe.
  - Final payload beat without `ctrl_last`: go to DRAIN; no strobe.
  - Each of these is one error.
- Strobe outputs:
  - Strobes are one-hot on the latched stage id, high for exactly one cycle.
  - Data/address outputs hold their last written value between writes.

## Timing
- Reset values: all outputs 0; FSM in IDLE. `ctrl_ready` is 0 during reset, then 1 the first cycle after deassertion.
- `ctrl_ready`: 1 in all states except ISSUE (0 there).
- Strobe timing: the strobe is asserted the cycle after the final payload beat is accepted.
- Throughput:
  - CAM write: 1 + 28 beats + 1 issue cycle = 30 cycles minimum per message.
  - Action write: 3 cycles.
- Reset mid-message: the partial message is discarded and no strobe fires. Subsequent beats of that message are treated as a new header.
- `err_cnt` saturates at 16'hFFFF.

## Configuration
- `TABLE_CFG_ERR_CNT_EN` defined:
  - `err_cnt` port exists.
  - Increments by 1 on each error event, saturating.
  - Reset to 0.
- Undefined:
  - The port and counter are absent.
  - Error handling (drain/abort) is unchanged.

## Structure
- Shared package `hc_cfg_pkg` holds:
  - opcode constants `OP_CAM_WR` = 4'd1 and `OP_ACT_WR` = 4'd2;
  - the header field bit positions;
  - the FSM state enum.
- One sub-module, `cfg_beat_shifter`: parameterised wide shift register with load and enable, instantiated for key and mask.

## Test plan
- CAM write, stage 2, addr 5, key beats 64'h1..64'hE, mask all-ones → after the last beat, `lookup_din_en` = 5'b00100 for 1 cycle; `lookup_din_addr` = 5; `lookup_din[63:0]` = 1; `lookup_din[895:832]` = 14; mask all-ones.
- Action write, stage 4, addr 15, data 64'h1AB_CDEF → `action_en` = 5'b10000 one cycle later; `action_data_in` = 25'h1ABCDEF; `ctrl_ready` = 0 in that cycle.
- Header with stage id 6 followed by 3 beats, last on beat 3 → no strobes; next valid header is accepted; `err_cnt` = 1.
- CAM message with `ctrl_last` on key beat 7 → no strobe; FSM in IDLE; `err_cnt` +1.
- `aresetn` low during mask beat 10, then a full action write → only the action strobe fires; all outputs were 0 during reset.
- Back-to-back action writes with `ctrl_valid` held high → strobes every 3 cycles; no beat lost across the ISSUE stall.

Source files
------------

// File: rtl/hc_cfg_pkg.sv
// Shared definitions for the table configuration writer: opcodes, header field
// positions and the writer FSM state encoding.
package hc_cfg_pkg;

    localparam logic [3:0] OP_CAM_WR = 4'd1;
    localparam logic [3:0] OP_ACT_WR = 4'd2;

    localparam int HDR_OP_MSB  = 63;
    localparam int HDR_OP_LSB  = 60;
    localparam int HDR_SID_MSB = 59;
    localparam int HDR_SID_LSB = 57;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KEY   = 3'd1,
        ST_MASK  = 3'd2,
        ST_ACT   = 3'd3,
        ST_ISSUE = 3'd4,
        ST_DRAIN = 3'd5
    } cfg_state_e;

    function automatic logic op_is_valid(input logic [3:0] op);
        return (op == OP_CAM_WR) || (op == OP_ACT_WR);
    endfunction

endpackage

// File: rtl/cfg_beat_shifter.sv
// Wide shift register that accumulates stream beats, least-significant beat first.
// load_i restarts accumulation from an all-zero value.
module cfg_beat_shifter #(
    parameter int WIDTH  = 896,
    parameter int BEAT_W = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              en_i,
    input  logic [BEAT_W-1:0] beat_i,
    output logic [WIDTH-1:0]  q_o
);

    logic [WIDTH-1:0] shift_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
        end else if (load_i) begin
            shift_q <= '0;
        end else if (en_i) begin
            shift_q <= {beat_i, shift_q[WIDTH-1:BEAT_W]};
        end
    end

    assign q_o = shift_q;

endmodule

// File: rtl/table_cfg_writer.sv
// Reassembles CAM (key+mask) and action configuration messages and issues one-cycle
// write strobes to the addressed stage. Optional error counter: TABLE_CFG_ERR_CNT_EN.
module table_cfg_writer
    import hc_cfg_pkg::*;
#(
    parameter int KEY_LEN    = 896,
    parameter int MASK_LEN   = 896,
    parameter int ACTION_LEN = 25,
    parameter int ADDR_W     = 4,
    parameter int NUM_STAGES = 5,
    parameter int CTRL_W     = 64
) (
    input  logic                  axis_clk,
    input  logic                  aresetn,
    input  logic [CTRL_W-1:0]     ctrl_data,
    input  logic                  ctrl_valid,
    input  logic                  ctrl_last,
    output logic                  ctrl_ready,
    output logic [KEY_LEN-1:0]    lookup_din,
    output logic [MASK_LEN-1:0]   lookup_din_mask,
    output logic [ADDR_W-1:0]     lookup_din_addr,
    output logic [NUM_STAGES-1:0] lookup_din_en,
    output logic [ACTION_LEN-1:0] action_data_in,
    output logic [ADDR_W-1:0]     action_addr,
    output logic [NUM_STAGES-1:0] action_en
`ifdef TABLE_CFG_ERR_CNT_EN
    ,
    output logic [15:0]           err_cnt
`endif
);

    localparam int KEY_BEATS = KEY_LEN / CTRL_W;
    localparam int CNT_W     = $clog2(KEY_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT    = CNT_W'(KEY_BEATS - 1);
    localparam logic [2:0]       NUM_STAGES_L = 3'(NUM_STAGES);

    cfg_state_e state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        stage_q, stage_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ready_q;

    logic [3:0] hdr_op;
    logic [2:0] hdr_sid;
    logic       hdr_ok;
    logic       fire;
    logic       shift_load, key_shift, mask_shift;
    logic       cam_issue, act_issue, err_evt;

    logic [KEY_LEN-1:0]    key_q;
    logic [MASK_LEN-1:0]   mask_q;
    logic [CTRL_W-1:0]     mask_lsb_unused;
    logic [NUM_STAGES-1:0] stage_oh;

    logic [KEY_LEN-1:0]    lookup_din_q;
    logic [MASK_LEN-1:0]   lookup_mask_q;
    logic [ADDR_W-1:0]     lookup_addr_q, action_addr_q;
    logic [NUM_STAGES-1:0] lookup_en_q, action_en_q;
    logic [ACTION_LEN-1:0] action_data_q;

    assign fire     = ctrl_valid && ready_q;
    assign hdr_op   = ctrl_data[HDR_OP_MSB:HDR_OP_LSB];
    assign hdr_sid  = ctrl_data[HDR_SID_MSB:HDR_SID_LSB];
    assign hdr_ok   = op_is_valid(hdr_op) && (hdr_sid < NUM_STAGES_L);
    assign stage_oh = NUM_STAGES'(1) << stage_q;
    assign mask_lsb_unused = mask_q[CTRL_W-1:0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stage_d    = stage_q;
        addr_d     = addr_q;
        shift_load = 1'b0;
        key_shift  = 1'b0;
        mask_shift = 1'b0;
        cam_issue  = 1'b0;
        act_issue  = 1'b0;
        err_evt    = 1'b0;
        case (state_q)
            ST_IDLE: if (fire) begin
                if (hdr_ok) begin
                    stage_d = hdr_sid;
                    addr_d  = ctrl_data[ADDR_W-1:0];
                    cnt_d   = '0;
                    // A header that is also the last beat has no payload at all.
                    if (ctrl_last) begin
                        err_evt = 1'b1;
                    end else if (hdr_op == OP_CAM_WR) begin
                        state_d    = ST_KEY;
                        shift_load = 1'b1;
                    end else begin
                        state_d = ST_ACT;
                    end
                end else begin
                    err_evt = 1'b1;
                    state_d = ctrl_last ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_KEY: if (fire) begin
                key_shift = 1'b1;
                if (ctrl_last) begin
                    err_evt = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == LAST_BEAT) begin
                    cnt_d   = '0;
                    state_d = ST_MASK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_MASK: if (fire) begin
                mask_shift = 1'b1;
                if (cnt_q == LAST_BEAT) begin
                    if (ctrl_last) begin
                        cam_issue = 1'b1;
                        state_d   = ST_ISSUE;
                    end else begin
                        err_evt = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end else if (ctrl_last) begin
                    err_evt = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_ACT: if (fire) begin
                if (ctrl_last) begin
                    act_issue = 1'b1;
                    state_d   = ST_ISSUE;
                end else begin
                    err_evt = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_ISSUE: state_d = ST_IDLE;
            ST_DRAIN: if (fire && ctrl_last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            stage_q <= '0;
            addr_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            addr_q  <= addr_d;
            ready_q <= (state_d != ST_ISSUE);
        end
    end

    cfg_beat_shifter #(.WIDTH(KEY_LEN), .BEAT_W(CTRL_W)) u_key_shifter (
        .clk_i  (axis_clk),
        .rst_ni (aresetn),
        .load_i (shift_load),
        .en_i   (key_shift),
        .beat_i (ctrl_data),
        .q_o    (key_q)
    );

    cfg_beat_shifter #(.WIDTH(MASK_LEN), .BEAT_W(CTRL_W)) u_mask_shifter (
        .clk_i  (axis_clk),
        .rst_ni (aresetn),
        .load_i (shift_load),
        .en_i   (mask_shift),
        .beat_i (ctrl_data),
        .q_o    (mask_q)
    );

    // Output copies are taken together with the final beat so the strobe cycle sees
    // complete data, and stay stable while the next message is being assembled.
    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            lookup_din_q  <= '0;
            lookup_mask_q <= '0;
            lookup_addr_q <= '0;
            lookup_en_q   <= '0;
            action_data_q <= '0;
            action_addr_q <= '0;
            action_en_q   <= '0;
        end else begin
            lookup_en_q <= '0;
            action_en_q <= '0;
            if (cam_issue) begin
                lookup_din_q  <= key_q;
                lookup_mask_q <= {ctrl_data, mask_q[MASK_LEN-1:CTRL_W]};
                lookup_addr_q <= addr_q;
                lookup_en_q   <= stage_oh;
            end
            if (act_issue) begin
                action_data_q <= ctrl_data[ACTION_LEN-1:0];
                action_addr_q <= addr_q;
                action_en_q   <= stage_oh;
            end
        end
    end

    assign ctrl_ready      = ready_q;
    assign lookup_din      = lookup_din_q;
    assign lookup_din_mask = lookup_mask_q;
    assign lookup_din_addr = lookup_addr_q;
    assign lookup_din_en   = lookup_en_q;
    assign action_data_in  = action_data_q;
    assign action_addr     = action_addr_q;
    assign action_en       = action_en_q;

`ifdef TABLE_CFG_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge axis_clk or negedge aresetn) begin
        if (!aresetn) begin
            err_cnt_q <= '0;
        end else if (err_evt && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic err_unused;
    assign err_unused = err_evt;
`endif

endmodule

// File: tb/tb_table_cfg_writer.sv
// Directed bench for table_cfg_writer: expected writes are queued as messages are sent
// and checked when the strobes appear. Checks err_cnt when TABLE_CFG_ERR_CNT_EN is set.
module tb_table_cfg_writer;

    typedef struct {
        bit           isCam;
        logic [2:0]   stage;
        logic [3:0]   addr;
        logic [895:0] key;
        logic [895:0] mask;
        logic [24:0]  act;
    } exp_t;

    logic         axis_clk;
    logic         aresetn;
    logic [63:0]  ctrl_data;
    logic         ctrl_valid;
    logic         ctrl_last;
    logic         ctrl_ready;
    logic [895:0] lookup_din;
    logic [895:0] lookup_din_mask;
    logic [3:0]   lookup_din_addr;
    logic [4:0]   lookup_din_en;
    logic [24:0]  action_data_in;
    logic [3:0]   action_addr;
    logic [4:0]   action_en;
`ifdef TABLE_CFG_ERR_CNT_EN
    logic [15:0]  err_cnt;
    int           errExp = 0;
`endif

    int     vectors     = 0;
    int     miscompares = 0;
    int     cyc         = 0;
    logic   prevFinal   = 1'b0;
    exp_t   sb[$];
    int     strobeLog[$];
    exp_t   mon;

    logic [895:0] key1, mask1, key2;

    table_cfg_writer dut (
        .axis_clk        (axis_clk),
        .aresetn         (aresetn),
        .ctrl_data       (ctrl_data),
        .ctrl_valid      (ctrl_valid),
        .ctrl_last       (ctrl_last),
        .ctrl_ready      (ctrl_ready),
        .lookup_din      (lookup_din),
        .lookup_din_mask (lookup_din_mask),
        .lookup_din_addr (lookup_din_addr),
        .lookup_din_en   (lookup_din_en),
        .action_data_in  (action_data_in),
        .action_addr     (action_addr),
        .action_en       (action_en)
`ifdef TABLE_CFG_ERR_CNT_EN
        ,
        .err_cnt         (err_cnt)
`endif
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    always @(posedge axis_clk) begin
        cyc       <= cyc + 1;
        prevFinal <= ctrl_valid && ctrl_ready && ctrl_last;
    end

    task automatic checkOutput(input string tag, input logic [895:0] obs, input logic [895:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mkHdr(input logic [3:0] op, input logic [2:0] sid, input logic [3:0] addr);
        return {op, sid, 53'd0, addr};
    endfunction

    // Called at a negedge; returns at the negedge after the beat was accepted.
    task automatic applyStimulus(input logic [63:0] d, input logic last);
        int guard;
        guard = 0;
        ctrl_data  = d;
        ctrl_valid = 1'b1;
        ctrl_last  = last;
        while (ctrl_ready !== 1'b1 && guard < 64) begin
            @(negedge axis_clk);
            guard++;
        end
        if (guard >= 64) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL ready_timeout: observed ctrl_ready=%b expected 1 within 64 cycles", ctrl_ready);
        end
        @(negedge axis_clk);
    endtask

    task automatic idleCycles(input int n);
        ctrl_valid = 1'b0;
        ctrl_last  = 1'b0;
        repeat (n) @(negedge axis_clk);
    endtask

    task automatic camWrite(input logic [2:0] sid, input logic [3:0] addr,
                            input logic [895:0] key, input logic [895:0] mask);
        exp_t e;
        applyStimulus(mkHdr(4'd1, sid, addr), 1'b0);
        for (int i = 0; i < 14; i++) applyStimulus(key[i*64 +: 64], 1'b0);
        for (int i = 0; i < 13; i++) applyStimulus(mask[i*64 +: 64], 1'b0);
        e.isCam = 1'b1; e.stage = sid; e.addr = addr; e.key = key; e.mask = mask; e.act = '0;
        sb.push_back(e);
        applyStimulus(mask[13*64 +: 64], 1'b1);
    endtask

    task automatic actWrite(input logic [2:0] sid, input logic [3:0] addr, input logic [63:0] data);
        exp_t e;
        applyStimulus(mkHdr(4'd2, sid, addr), 1'b0);
        e.isCam = 1'b0; e.stage = sid; e.addr = addr; e.key = '0; e.mask = '0; e.act = data[24:0];
        sb.push_back(e);
        applyStimulus(data, 1'b1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_lookup_din"}, lookup_din, '0);
        checkOutput({tag, "_lookup_mask"}, lookup_din_mask, '0);
        checkOutput({tag, "_lookup_addr"}, lookup_din_addr, '0);
        checkOutput({tag, "_lookup_en"}, lookup_din_en, '0);
        checkOutput({tag, "_action_data"}, action_data_in, '0);
        checkOutput({tag, "_action_addr"}, action_addr, '0);
        checkOutput({tag, "_action_en"}, action_en, '0);
        checkOutput({tag, "_ctrl_ready"}, ctrl_ready, 1'b0);
    endtask

    // Strobe monitor: every strobe cycle must match the oldest queued write.
    always @(posedge axis_clk) begin
        #2;
        if (lookup_din_en !== 5'b0 || action_en !== 5'b0) begin
            strobeLog.push_back(cyc);
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $error("[TB] FAIL unexpected_strobe: observed lookup_din_en=%b action_en=%b expected no strobe",
                       lookup_din_en, action_en);
            end else begin
                mon = sb.pop_front();
                checkOutput("strobe_timing", prevFinal, 1'b1);
                checkOutput("ready_in_issue", ctrl_ready, 1'b0);
                if (mon.isCam) begin
                    checkOutput("cam_en", lookup_din_en, 5'b00001 << mon.stage);
                    checkOutput("cam_act_en_quiet", action_en, 5'b0);
                    checkOutput("cam_addr", lookup_din_addr, mon.addr);
                    checkOutput("cam_key", lookup_din, mon.key);
                    checkOutput("cam_mask", lookup_din_mask, mon.mask);
                end else begin
                    checkOutput("act_en", action_en, 5'b00001 << mon.stage);
                    checkOutput("act_cam_en_quiet", lookup_din_en, 5'b0);
                    checkOutput("act_addr", action_addr, mon.addr);
                    checkOutput("act_data", action_data_in, mon.act);
                end
            end
        end
    end

    initial begin
        aresetn    = 1'b0;
        ctrl_data  = '0;
        ctrl_valid = 1'b0;
        ctrl_last  = 1'b0;
        for (int i = 0; i < 14; i++) begin
            key1[i*64 +: 64] = 64'(i + 1);
            key2[i*64 +: 64] = 64'hA5A5_0000_0000_0000 | 64'(i * 3);
        end
        mask1 = '1;

        $display("[TB] reset phase");
        repeat (3) @(negedge axis_clk);
        checkAllZero("reset");
        aresetn = 1'b1;
        @(negedge axis_clk);
        checkOutput("ready_after_reset", ctrl_ready, 1'b1);

        $display("[TB] CAM write stage 2 addr 5");
        camWrite(3'd2, 4'd5, key1, mask1);
        idleCycles(2);
        checkOutput("key_low_beat", lookup_din[63:0], 64'd1);
        checkOutput("key_high_beat", lookup_din[895:832], 64'd14);

        $display("[TB] action write stage 4 addr 15");
        actWrite(3'd4, 4'd15, 64'h1AB_CDEF);
        idleCycles(2);
        checkOutput("hold_key", lookup_din, key1);
        checkOutput("hold_cam_addr", lookup_din_addr, 4'd5);

        $display("[TB] bad stage id header then drain");
        applyStimulus(mkHdr(4'd1, 3'd6, 4'd2), 1'b0);
        applyStimulus(64'h1111, 1'b0);
        applyStimulus(64'h2222, 1'b0);
        applyStimulus(mkHdr(4'd2, 3'd1, 4'd1), 1'b1);
`ifdef TABLE_CFG_ERR_CNT_EN
        errExp++;
`endif
        actWrite(3'd0, 4'd3, 64'hFFFF_FFFF_0055_AA11);
        idleCycles(2);
`ifdef TABLE_CFG_ERR_CNT_EN
        checkOutput("err_cnt_bad_stage", err_cnt, 16'(errExp));
`endif

        $display("[TB] CAM message truncated on key beat 7");
        applyStimulus(mkHdr(4'd1, 3'd3, 4'd4), 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(key2[i*64 +: 64], i == 7);
`ifdef TABLE_CFG_ERR_CNT_EN
        errExp++;
`endif
        idleCycles(2);
        checkOutput("ready_after_abort", ctrl_ready, 1'b1);
        actWrite(3'd1, 4'd7, 64'h0000_0000_0123_4567);
        idleCycles(2);
`ifdef TABLE_CFG_ERR_CNT_EN
        checkOutput("err_cnt_abort", err_cnt, 16'(errExp));
`endif

        $display("[TB] invalid opcode header with last, action beat without last");
        applyStimulus(mkHdr(4'd7, 3'd0, 4'd0), 1'b1);
        applyStimulus(mkHdr(4'd2, 3'd3, 4'd6), 1'b0);
        applyStimulus(64'h0BAD, 1'b0);
        applyStimulus(64'h0BEE, 1'b1);
`ifdef TABLE_CFG_ERR_CNT_EN
        errExp += 2;
`endif
        camWrite(3'd0, 4'd9, key2, ~key2);
        idleCycles(2);
`ifdef TABLE_CFG_ERR_CNT_EN
        checkOutput("err_cnt_opcode_drain", err_cnt, 16'(errExp));
`endif

        $display("[TB] back-to-back action writes");
        strobeLog.delete();
        actWrite(3'd0, 4'd1, 64'h0000_0000_0000_0101);
        actWrite(3'd2, 4'd2, 64'h0000_0000_0000_0202);
        actWrite(3'd4, 4'd3, 64'h0000_0000_0000_0303);
        idleCycles(3);
        checkOutput("b2b_count", strobeLog.size(), 3);
        for (int i = 1; i < strobeLog.size(); i++)
            checkOutput("b2b_spacing", strobeLog[i] - strobeLog[i-1], 3);

        $display("[TB] reset during mask beat 10");
        applyStimulus(mkHdr(4'd1, 3'd2, 4'd8), 1'b0);
        for (int i = 0; i < 14; i++) applyStimulus(key2[i*64 +: 64], 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(mask1[i*64 +: 64], 1'b0);
        ctrl_data  = mask1[10*64 +: 64];
        ctrl_valid = 1'b1;
        aresetn    = 1'b0;
        #1;
        checkAllZero("midreset");
`ifdef TABLE_CFG_ERR_CNT_EN
        errExp = 0;
        checkOutput("err_cnt_reset", err_cnt, 16'd0);
`endif
        idleCycles(2);
        aresetn = 1'b1;
        @(negedge axis_clk);
        checkOutput("ready_after_midreset", ctrl_ready, 1'b1);
        strobeLog.delete();
        actWrite(3'd3, 4'd12, 64'h0000_0000_00C0_FFEE);
        idleCycles(4);
        checkOutput("midreset_strobe_count", strobeLog.size(), 1);
        checkOutput("midreset_cam_quiet", lookup_din, '0);

        idleCycles(5);
        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
